console_hq_multi: RTL and testbench

//  Parametrised successor of the console sequencer. It configures and samples NCH ADC/USB channels with per-channel fs/fd

---
 rtl/console_hq_multi.sv | 184 ++++++++++++++++++
 tb/tb_console_hq_multi.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_hq_multi.sv
// Multi-channel ADC/USB console sequencer: per-channel config and conversion handshakes,
// a programmable sample tick, config-ack and data frames to comms, graceful stop and overrun counting.
module console_hq_multi #(
  parameter int NCH   = 8,
  parameter int IDX_W = 4,
  parameter int DIV_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCH-1:0]   ch_en_i,
  input  logic [DIV_W-1:0] tick_div_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [NCH-1:0]   fs_conf_o,
  input  logic [NCH-1:0]   fd_conf_i,
  output logic [NCH-1:0]   fs_conv_o,
  input  logic [NCH-1:0]   fd_conv_i,
  output logic             fs_com_send_o,
  input  logic             fd_com_send_i,
  output logic [3:0]       com_send_btype_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [15:0]      overrun_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StConf,
    StAck,
    StWait,
    StConv,
    StSend
  } state_e;

  state_e           state_q;
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   done_q;
  logic [NCH-1:0]   fs_conf_q;
  logic [NCH-1:0]   fs_conv_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             stop_q;
  logic             fs_com_send_q;
  logic [3:0]       btype_q;
  logic [IDX_W-1:0] data_idx_q;
  logic             busy_q;
  logic             overrun_q;
  logic [15:0]      overrun_cnt_q;

  logic             tick;
  logic             late_tick;
  logic             com_ack;
  logic             cnt_run;
  logic [NCH-1:0]   conf_done_d;
  logic [NCH-1:0]   conv_done_d;

  // A done bit only counts when its request is actually raised, so stray fd pulses are ignored.
  assign tick        = (cnt_q == div_q);
  assign cnt_run     = (state_q == StAck) || (state_q == StWait) ||
                       (state_q == StConv) || (state_q == StSend);
  assign late_tick   = tick && ((state_q == StConv) || (state_q == StSend));
  assign com_ack     = fs_com_send_q & fd_com_send_i;
  assign conf_done_d = done_q | (fd_conf_i & fs_conf_q);
  assign conv_done_d = done_q | (fd_conv_i & fs_conv_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      en_q          <= '0;
      done_q        <= '0;
      fs_conf_q     <= '0;
      fs_conv_q     <= '0;
      div_q         <= '0;
      cnt_q         <= '0;
      stop_q        <= 1'b0;
      fs_com_send_q <= 1'b0;
      btype_q       <= 4'h0;
      data_idx_q    <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      if (cnt_run) begin
        cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
      end
      // A tick that lands while a frame is still in flight is dropped and only accounted for.
      if (late_tick) begin
        overrun_q <= 1'b1;
        if (overrun_cnt_q != 16'hFFFF) begin
          overrun_cnt_q <= overrun_cnt_q + 16'd1;
        end
      end
      if (stop_i && (state_q != StIdle)) begin
        stop_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          cnt_q  <= '0;
          stop_q <= 1'b0;
          if (start_i && (ch_en_i != '0)) begin
            state_q       <= StConf;
            en_q          <= ch_en_i;
            div_q         <= tick_div_i;
            done_q        <= '0;
            fs_conf_q     <= ch_en_i;
            busy_q        <= 1'b1;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
          end
        end
        StConf: begin
          if (conf_done_d == en_q) begin
            state_q       <= StAck;
            done_q        <= '0;
            fs_conf_q     <= '0;
            fs_com_send_q <= 1'b1;
            btype_q       <= 4'h2;
          end else begin
            done_q    <= conf_done_d;
            fs_conf_q <= en_q & ~conf_done_d;
          end
        end
        StAck: begin
          if (com_ack) begin
            state_q       <= StWait;
            fs_com_send_q <= 1'b0;
            btype_q       <= 4'h0;
            data_idx_q    <= '0;
            cnt_q         <= '0;
          end
        end
        StWait: begin
          if (stop_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
          end else if (tick) begin
            state_q   <= StConv;
            fs_conv_q <= en_q;
          end
        end
        StConv: begin
          if (conv_done_d == en_q) begin
            state_q       <= StSend;
            done_q        <= '0;
            fs_conv_q     <= '0;
            fs_com_send_q <= 1'b1;
            btype_q       <= 4'h1;
          end else begin
            done_q    <= conv_done_d;
            fs_conv_q <= en_q & ~conv_done_d;
          end
        end
        StSend: begin
          if (com_ack) begin
            data_idx_q    <= data_idx_q + IDX_W'(1);
            fs_com_send_q <= 1'b0;
            btype_q       <= 4'h0;
            if (stop_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              stop_q  <= 1'b0;
            end else begin
              state_q <= StWait;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fs_conf_o        = fs_conf_q;
  assign fs_conv_o        = fs_conv_q;
  assign fs_com_send_o    = fs_com_send_q;
  assign com_send_btype_o = btype_q;
  assign data_idx_o       = data_idx_q;
  assign busy_o           = busy_q;
  assign overrun_o        = overrun_q;
  assign overrun_cnt_o    = overrun_cnt_q;

endmodule

// File: tb/tb_console_hq_multi.sv
// Self-checking bench for console_hq_multi: randomized responders, expected timing and
// counters derived arithmetically from the tick period and handshake latencies.
module tb_console_hq_multi;
  localparam int NCH   = 8;
  localparam int IDX_W = 4;
  localparam int DIV_W = 24;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [NCH-1:0]   ch_en_i = '0;
  logic [DIV_W-1:0] tick_div_i = '0;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [NCH-1:0]   fs_conf_o;
  logic [NCH-1:0]   fd_conf_i = '0;
  logic [NCH-1:0]   fs_conv_o;
  logic [NCH-1:0]   fd_conv_i = '0;
  logic             fs_com_send_o;
  logic             fd_com_send_i = 1'b0;
  logic [3:0]       com_send_btype_o;
  logic [IDX_W-1:0] data_idx_o;
  logic             busy_o;
  logic             overrun_o;
  logic [15:0]      overrun_cnt_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int confLat[NCH];
  int convLat[NCH];
  int comLat;
  int confCnt[NCH];
  int convCnt[NCH];
  int comCnt;

  console_hq_multi #(.NCH(NCH), .IDX_W(IDX_W), .DIV_W(DIV_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ch_en_i(ch_en_i), .tick_div_i(tick_div_i),
    .start_i(start_i), .stop_i(stop_i), .fs_conf_o(fs_conf_o), .fd_conf_i(fd_conf_i),
    .fs_conv_o(fs_conv_o), .fd_conv_i(fd_conv_i), .fs_com_send_o(fs_com_send_o),
    .fd_com_send_i(fd_com_send_i), .com_send_btype_o(com_send_btype_o),
    .data_idx_o(data_idx_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .overrun_cnt_o(overrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Responders answer a raised request after a fixed number of cycles; idle lines carry junk.
  task automatic respond();
    for (int i = 0; i < NCH; i++) begin
      if (fs_conf_o[i]) begin
        if (confCnt[i] == confLat[i]) begin fd_conf_i[i] = 1'b1; confCnt[i] = 0; end
        else begin fd_conf_i[i] = 1'b0; confCnt[i]++; end
      end else begin
        fd_conf_i[i] = 1'($urandom); confCnt[i] = 0;
      end
      if (fs_conv_o[i]) begin
        if (convCnt[i] == convLat[i]) begin fd_conv_i[i] = 1'b1; convCnt[i] = 0; end
        else begin fd_conv_i[i] = 1'b0; convCnt[i]++; end
      end else begin
        fd_conv_i[i] = 1'($urandom); convCnt[i] = 0;
      end
    end
    if (fs_com_send_o) begin
      if (comCnt == comLat) begin fd_com_send_i = 1'b1; comCnt = 0; end
      else begin fd_com_send_i = 1'b0; comCnt++; end
    end else begin
      fd_com_send_i = 1'($urandom); comCnt = 0;
    end
  endtask

  task automatic startSession(input logic [NCH-1:0] en, input int div);
    for (int i = 0; i < NCH; i++) begin confCnt[i] = 0; convCnt[i] = 0; end
    comCnt = 0;
    ch_en_i = en;
    tick_div_i = DIV_W'(div);
    start_i = 1'b1;
    nextCycle();
    start_i = 1'b0;
    ch_en_i = NCH'($urandom);
    tick_div_i = DIV_W'($urandom);
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    stop_i = 1'b1;
    respond();
    nextCycle();
    stop_i = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      if (!busy_o) ok = 1'b1;
      else begin respond(); nextCycle(); end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) nextCycle();
    compared++;
    if ({fs_conf_o, fs_conv_o, fs_com_send_o, com_send_btype_o} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_req: got %h expected 0", {fs_conf_o, fs_conv_o, fs_com_send_o, com_send_btype_o});
    end
    compared++;
    if ({busy_o, overrun_o, data_idx_o, overrun_cnt_o} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_status: got %h expected 0", {busy_o, overrun_o, data_idx_o, overrun_cnt_o});
    end
    rst_ni = 1'b1;
    nextCycle();
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_conf_handshake(input logic [NCH-1:0] enIn, input bit randomize);
    int doneCyc[NCH];
    int maxD;
    logic [NCH-1:0] en;
    logic [NCH-1:0] expMask;
    bit ok;
    en = randomize ? enIn : 8'h05;
    maxD = 0;
    for (int i = 0; i < NCH; i++) begin
      doneCyc[i] = randomize ? $urandom_range(1, 6) : ((i == 0) ? 3 : 6);
      if (en[i] && doneCyc[i] > maxD) maxD = doneCyc[i];
    end
    startSession(en, 50);
    for (int c = 1; c <= maxD + 1; c++) begin
      expMask = '0;
      for (int i = 0; i < NCH; i++) if (en[i] && c <= doneCyc[i]) expMask[i] = 1'b1;
      compared++;
      if (fs_conf_o !== expMask) begin
        mismatched++;
        $display("[TB] FAIL conf_mask c%0d: got %h expected %h", c, fs_conf_o, expMask);
      end
      compared++;
      if (fs_com_send_o !== (c == maxD + 1)) begin
        mismatched++;
        $display("[TB] FAIL conf_ack_req c%0d: got %b expected %b", c, fs_com_send_o, (c == maxD + 1));
      end
      if (c == maxD + 1) begin
        compared++;
        if (com_send_btype_o !== 4'h2) begin
          mismatched++;
          $display("[TB] FAIL ack_btype: got %h expected 2", com_send_btype_o);
        end
      end
      for (int i = 0; i < NCH; i++)
        fd_conf_i[i] = !en[i] ? 1'($urandom) : (c == doneCyc[i]) ? 1'b1 :
                       (c > doneCyc[i]) ? 1'($urandom) : 1'b0;
      fd_com_send_i = (c == maxD + 1) ? 1'b1 : 1'($urandom);
      if (c <= maxD) nextCycle();
    end
    nextCycle();
    fd_com_send_i = 1'b0;
    fd_conf_i = '0;
    compared++;
    if ({fs_com_send_o, com_send_btype_o, busy_o, data_idx_o, fs_conf_o} !== {1'b0, 4'h0, 1'b1, IDX_W'(0), NCH'(0)}) begin
      mismatched++;
      $display("[TB] FAIL ack_exit: got com=%b bt=%h busy=%b idx=%0d conf=%h expected 0 0 1 0 0",
               fs_com_send_o, com_send_btype_o, busy_o, data_idx_o, fs_conf_o);
    end
    waitIdle(10, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL conf_stop_idle: busy=%b expected 0", busy_o); end
  endtask

  task automatic test_sampling(input int div, input int nframes, input int lat, input bit randLat);
    logic [NCH-1:0] en;
    logic [NCH-1:0] prevConv;
    int rises, lastRise, ackDone, sendDone, expRise, budget;
    bit stopped, finished, activity;
    do en = NCH'($urandom); while (en == '0);
    for (int i = 0; i < NCH; i++) begin
      confLat[i] = randLat ? $urandom_range(0, 3) : lat;
      convLat[i] = randLat ? $urandom_range(0, 3) : lat;
    end
    comLat = randLat ? $urandom_range(0, 3) : lat;
    startSession(en, div);
    rises = 0; lastRise = 0; ackDone = -1000; sendDone = -1; stopped = 0; finished = 0; prevConv = '0;
    budget = (nframes + 3) * (div + 1) + 100;
    for (int t = 0; t < budget && !finished; t++) begin
      if (fs_conv_o != '0 && prevConv == '0) begin
        expRise = (rises == 0) ? ackDone + div + 2 : lastRise + div + 1;
        compared++;
        if (cyc !== expRise) begin
          mismatched++;
          $display("[TB] FAIL tick_rise %0d: got cycle %0d expected %0d", rises, cyc, expRise);
        end
        compared++;
        if (fs_conv_o !== en) begin
          mismatched++;
          $display("[TB] FAIL conv_mask: got %h expected %h", fs_conv_o, en);
        end
        compared++;
        if (data_idx_o !== IDX_W'(rises)) begin
          mismatched++;
          $display("[TB] FAIL data_idx frame %0d: got %0d expected %0d", rises, data_idx_o, rises % (1 << IDX_W));
        end
        lastRise = cyc;
        rises++;
        if (rises == 4) begin start_i = 1'b1; ch_en_i = NCH'($urandom); tick_div_i = DIV_W'($urandom); end
        if (rises == nframes) begin stop_i = 1'b1; stopped = 1; end
      end
      prevConv = fs_conv_o;
      respond();
      if (fs_com_send_o && fd_com_send_i) begin
        if (com_send_btype_o == 4'h2) ackDone = cyc;
        else if (stopped) sendDone = cyc;
      end
      nextCycle();
      start_i = 1'b0;
      stop_i = 1'b0;
      if (sendDone >= 0) begin
        finished = 1;
        compared++;
        if (busy_o !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL stop_idle: got busy=%b expected 0", busy_o);
        end
        compared++;
        if (data_idx_o !== IDX_W'(nframes)) begin
          mismatched++;
          $display("[TB] FAIL final_idx: got %0d expected %0d", data_idx_o, nframes % (1 << IDX_W));
        end
      end
    end
    compared++;
    if (!finished) begin mismatched++; $display("[TB] FAIL sampling_timeout: frames %0d expected %0d", rises, nframes); end
    activity = 0;
    for (int t = 0; t < 2 * (div + 1); t++) begin
      respond();
      nextCycle();
      if (fs_conv_o != '0 || busy_o) activity = 1;
    end
    compared++;
    if (activity) begin mismatched++; $display("[TB] FAIL after_stop_activity: got 1 expected 0"); end
    compared++;
    if ({overrun_o, overrun_cnt_o} !== 17'd0) begin
      mismatched++;
      $display("[TB] FAIL no_overrun: got ov=%b cnt=%0d expected 0 0", overrun_o, overrun_cnt_o);
    end
  endtask

  task automatic test_overrun(input int div, input int nframes, input int comL, input int fixedH);
    logic [NCH-1:0] en;
    logic [NCH-1:0] prevConv;
    int rises, ackDone, sendDone, expRise, nextExp, expOv, h, m, budget;
    bit stopped, finished;
    do en = NCH'($urandom); while (en == '0);
    for (int i = 0; i < NCH; i++) confLat[i] = 0;
    comLat = comL;
    startSession(en, div);
    compared++;
    if ({overrun_o, overrun_cnt_o} !== 17'd0) begin
      mismatched++;
      $display("[TB] FAIL overrun_clear: got ov=%b cnt=%0d expected 0 0", overrun_o, overrun_cnt_o);
    end
    rises = 0; ackDone = -1000; sendDone = -1; stopped = 0; finished = 0; prevConv = '0;
    expOv = 0; nextExp = 0;
    budget = nframes * (40 + 2 * (div + 1)) + 100;
    for (int t = 0; t < budget && !finished; t++) begin
      if (fs_conv_o != '0 && prevConv == '0) begin
        expRise = (rises == 0) ? ackDone + div + 2 : nextExp;
        compared++;
        if (cyc !== expRise) begin
          mismatched++;
          $display("[TB] FAIL ov_rise %0d: got cycle %0d expected %0d", rises, cyc, expRise);
        end
        compared++;
        if (overrun_cnt_o !== 16'(expOv) || overrun_o !== (expOv != 0)) begin
          mismatched++;
          $display("[TB] FAIL ov_count %0d: got %0d/%b expected %0d/%b", rises, overrun_cnt_o, overrun_o, expOv, expOv != 0);
        end
        compared++;
        if (data_idx_o !== IDX_W'(rises)) begin
          mismatched++;
          $display("[TB] FAIL ov_idx %0d: got %0d expected %0d", rises, data_idx_o, rises % (1 << IDX_W));
        end
        // Ticks at multiples of the period after this one: those before WAIT resumes are lost.
        h = (fixedH >= 0) ? fixedH : $urandom_range(0, 15);
        for (int i = 0; i < NCH; i++) convLat[i] = h;
        expOv += (2 + h + comL) / (div + 1);
        m = (3 + h + comL + div) / (div + 1);
        nextExp = (cyc - 1) + m * (div + 1) + 1;
        rises++;
        if (rises == nframes) begin stop_i = 1'b1; stopped = 1; end
      end
      prevConv = fs_conv_o;
      respond();
      if (fs_com_send_o && fd_com_send_i) begin
        if (com_send_btype_o == 4'h2) ackDone = cyc;
        else if (stopped) sendDone = cyc;
      end
      nextCycle();
      stop_i = 1'b0;
      if (sendDone >= 0) finished = 1;
    end
    compared++;
    if (!finished || busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ov_stop: got finished=%b busy=%b expected 1 0", finished, busy_o);
    end
    compared++;
    if (overrun_cnt_o !== 16'(expOv) || overrun_o !== (expOv != 0)) begin
      mismatched++;
      $display("[TB] FAIL ov_final: got %0d/%b expected %0d/%b", overrun_cnt_o, overrun_o, expOv, expOv != 0);
    end
  endtask

  task automatic test_reset_midconf();
    bit activity;
    for (int i = 0; i < NCH; i++) confLat[i] = 1000;
    startSession(8'hFF, 100);
    for (int c = 1; c < 4; c++) begin respond(); nextCycle(); end
    compared++;
    if (fs_conf_o !== 8'hFF || busy_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midconf_req: got %h/%b expected ff/1", fs_conf_o, busy_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    compared++;
    if ({fs_conf_o, fs_conv_o, fs_com_send_o, com_send_btype_o, data_idx_o, busy_o, overrun_o, overrun_cnt_o} !== '0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got conf=%h busy=%b idx=%0d expected all 0", fs_conf_o, busy_o, data_idx_o);
    end
    nextCycle();
    nextCycle();
    rst_ni = 1'b1;
    activity = 0;
    for (int t = 0; t < 10; t++) begin
      respond();
      nextCycle();
      if (busy_o || fs_conf_o != '0 || fs_conv_o != '0 || fs_com_send_o) activity = 1;
    end
    compared++;
    if (activity) begin mismatched++; $display("[TB] FAIL post_reset_activity: got 1 expected 0"); end
    for (int i = 0; i < NCH; i++) confLat[i] = 0;
  endtask

  task automatic test_ignored_start();
    logic [NCH-1:0] en;
    bit seen, ok;
    ch_en_i = '0;
    tick_div_i = DIV_W'(5);
    start_i = 1'b1;
    nextCycle();
    start_i = 1'b0;
    for (int t = 0; t < 5; t++) begin
      compared++;
      if (busy_o !== 1'b0 || fs_conf_o !== '0) begin
        mismatched++;
        $display("[TB] FAIL empty_mask_start: got busy=%b conf=%h expected 0 0", busy_o, fs_conf_o);
      end
      nextCycle();
    end
    stop_i = 1'b1;
    nextCycle();
    stop_i = 1'b0;
    do en = NCH'($urandom); while (en == '0);
    for (int i = 0; i < NCH; i++) begin confLat[i] = $urandom_range(0, 2); convLat[i] = $urandom_range(0, 2); end
    comLat = $urandom_range(0, 2);
    startSession(en, 20);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (fs_conv_o != '0) seen = 1;
      else begin respond(); nextCycle(); end
    end
    compared++;
    if (!seen || busy_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL idle_stop_ignored: got conv_seen=%b busy=%b expected 1 1", seen, busy_o);
    end
    waitIdle(40, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL ignored_start_idle: busy=%b expected 0", busy_o); end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin confLat[i] = 0; convLat[i] = 0; confCnt[i] = 0; convCnt[i] = 0; end
    comLat = 0;
    comCnt = 0;
    test_reset();
    test_conf_handshake('0, 1'b0);
    test_sampling(99, 20, 2, 1'b0);
    for (int k = 0; k < 3; k++) test_conf_handshake(NCH'($urandom_range(1, 255)), 1'b1);
    test_sampling($urandom_range(12, 40), 10, 0, 1'b1);
    test_overrun(3, 2, 1, 12);
    test_overrun($urandom_range(1, 5), 5, 1, -1);
    test_overrun(0, 3, 0, -1);
    test_reset_midconf();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
